// File: rtl/inert_intf.sv
// inert_intf: front end for inertial_integrator.
// Configures the IMU over the SPI monarch after power-up. On each data-ready
// interrupt it reads pitch rate and Z acceleration, one byte per transaction,
// then presents {ptch_rt, AZ} together with a single-cycle vld strobe.
module inert_intf #(
    parameter int INIT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [7:0]  resp,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld
);

    typedef enum logic [3:0] {
        INIT_WAIT,
        CFG1,
        CFG2,
        CFG3,
        CFG4,
        WAIT_INT,
        RD_PL,
        RD_PH,
        RD_AL,
        RD_AH,
        UPDATE
    } state_t;

    localparam logic [15:0] CMD_INT_CFG   = 16'h0D02;
    localparam logic [15:0] CMD_ACCEL_CFG = 16'h1053;
    localparam logic [15:0] CMD_GYRO_CFG  = 16'h1150;
    localparam logic [15:0] CMD_ROUND_CFG = 16'h1460;
    localparam logic [15:0] CMD_RD_PL     = 16'hA200;
    localparam logic [15:0] CMD_RD_PH     = 16'hA300;
    localparam logic [15:0] CMD_RD_AL     = 16'hAC00;
    localparam logic [15:0] CMD_RD_AH     = 16'hAD00;

    state_t state;
    state_t next_state;

    logic              int_ff1;
    logic              int_ff2;
    logic [INIT_W-1:0] init_cnt;
    logic              init_full;

    logic [7:0] pl;
    logic [7:0] ph;
    logic [7:0] al;

    logic        issue;
    logic [15:0] issue_cmd;
    logic        latch_pl;
    logic        latch_ph;
    logic        latch_al;
    logic        publish;

    // Bring the asynchronous IMU interrupt into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1 <= 1'b0;
            int_ff2 <= 1'b0;
        end else begin
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
        end
    end

    // Power-up wait counter, runs only while waiting for the IMU to boot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
        end else if (state == INIT_WAIT) begin
            init_cnt <= init_cnt + 1'b1;
        end else begin
            init_cnt <= '0;
        end
    end

    assign init_full = &init_cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: every SPI-backed state advances only on done
    always_comb begin
        next_state = state;
        case (state)
            INIT_WAIT: if (init_full) next_state = CFG1;
            CFG1:      if (done)      next_state = CFG2;
            CFG2:      if (done)      next_state = CFG3;
            CFG3:      if (done)      next_state = CFG4;
            CFG4:      if (done)      next_state = WAIT_INT;
            WAIT_INT:  if (int_ff2)   next_state = RD_PL;
            RD_PL:     if (done)      next_state = RD_PH;
            RD_PH:     if (done)      next_state = RD_AL;
            RD_AL:     if (done)      next_state = RD_AH;
            RD_AH:     if (done)      next_state = UPDATE;
            UPDATE:                   next_state = WAIT_INT;
            default:                  next_state = INIT_WAIT;
        endcase
    end

    // Output decode: which command to launch and which byte to capture on
    // the transition into the next state
    always_comb begin
        issue     = 1'b0;
        issue_cmd = 16'h0000;
        latch_pl  = 1'b0;
        latch_ph  = 1'b0;
        latch_al  = 1'b0;
        publish   = 1'b0;
        case (state)
            INIT_WAIT: begin
                issue     = init_full;
                issue_cmd = CMD_INT_CFG;
            end
            CFG1: begin
                issue     = done;
                issue_cmd = CMD_ACCEL_CFG;
            end
            CFG2: begin
                issue     = done;
                issue_cmd = CMD_GYRO_CFG;
            end
            CFG3: begin
                issue     = done;
                issue_cmd = CMD_ROUND_CFG;
            end
            WAIT_INT: begin
                issue     = int_ff2;
                issue_cmd = CMD_RD_PL;
            end
            RD_PL: begin
                issue     = done;
                issue_cmd = CMD_RD_PH;
                latch_pl  = done;
            end
            RD_PH: begin
                issue     = done;
                issue_cmd = CMD_RD_AL;
                latch_ph  = done;
            end
            RD_AL: begin
                issue     = done;
                issue_cmd = CMD_RD_AH;
                latch_al  = done;
            end
            RD_AH: begin
                publish   = done;
            end
            default: begin
                issue     = 1'b0;
            end
        endcase
    end

    // Byte holding registers for the partially assembled sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl <= 8'h00;
            ph <= 8'h00;
            al <= 8'h00;
        end else begin
            if (latch_pl) pl <= resp;
            if (latch_ph) ph <= resp;
            if (latch_al) al <= resp;
        end
    end

    // Registered outputs. The AZ high byte is taken straight from resp on the
    // final done so that ptch_rt, AZ and vld all appear in the UPDATE cycle,
    // one clock after that done, with no separate AH holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrt     <= 1'b0;
            cmd     <= 16'h0000;
            ptch_rt <= 16'h0000;
            AZ      <= 16'h0000;
            vld     <= 1'b0;
        end else begin
            wrt <= issue;
            vld <= publish;
            if (issue) cmd <= issue_cmd;
            if (publish) begin
                ptch_rt <= {ph, pl};
                AZ      <= {resp, al};
            end
        end
    end

endmodule

// File: tb/tb_inert_intf.sv
// Testbench for inert_intf with a cycle-level SPI monarch model.
module tb_inert_intf;

    logic        clk;
    logic        rst_n;
    logic        INT;
    logic        done;
    logic [7:0]  resp;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        vld;

    logic        done_spi;
    logic        spur;
    logic [15:0] cur_cmd;
    int          spi_cnt;
    int          cyc;
    int          first_wrt;
    int          vld_cnt;
    int          errors;
    int          checks;
    logic [15:0] cmd_log[$];
    logic [7:0]  resp_q[$];

    typedef struct {
        logic [7:0]  pl;
        logic [7:0]  ph;
        logic [7:0]  al;
        logic [7:0]  ah;
        logic [15:0] exp_p;
        logic [15:0] exp_a;
        bit          hold;
    } vec_t;

    vec_t vecs[3];

    assign done = done_spi | spur;

    inert_intf #(.INIT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .done    (done),
        .resp    (resp),
        .wrt     (wrt),
        .cmd     (cmd),
        .ptch_rt (ptch_rt),
        .AZ      (AZ),
        .vld     (vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number since reset release; the first rising edge after release is 1
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // SPI monarch model: done arrives 32 clocks after the wrt edge
    initial begin
        done_spi = 1'b0;
        resp     = 8'h00;
        spi_cnt  = 0;
        cur_cmd  = 16'h0000;
        forever begin
            @(negedge clk);
            done_spi = 1'b0;
            if (!rst_n) begin
                spi_cnt = 0;
            end else if (spi_cnt > 0) begin
                spi_cnt = spi_cnt - 1;
                if (spi_cnt == 0) begin
                    done_spi = 1'b1;
                    if (cur_cmd[15] && resp_q.size() > 0) resp = resp_q.pop_front();
                    else                                  resp = 8'h00;
                end
            end else if (wrt) begin
                if (cmd_log.size() == 0) first_wrt = cyc;
                cmd_log.push_back(cmd);
                cur_cmd = cmd;
                spi_cnt = 31;
            end
        end
    end

    // Count vld strobes
    initial begin
        vld_cnt = 0;
        forever begin
            @(negedge clk);
            if (vld) vld_cnt = vld_cnt + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_init_seq(input string tag);
        logic [15:0] exp_cfg[4];
        exp_cfg[0] = 16'h0D02;
        exp_cfg[1] = 16'h1053;
        exp_cfg[2] = 16'h1150;
        exp_cfg[3] = 16'h1460;
        check({tag, "_first_wrt_cycle"}, first_wrt, 256);
        check({tag, "_cmd_count"}, cmd_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < cmd_log.size()) check($sformatf("%s_cfg%0d", tag, i), cmd_log[i], exp_cfg[i]);
        end
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (cmd_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (cmd_log.size() < n) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int          k;
        int          prev_vld_cyc;
        int          n;
        int          vld_before;
        logic [15:0] exp_rd[4];

        errors    = 0;
        checks    = 0;
        first_wrt = -1;
        rst_n     = 1'b0;
        INT       = 1'b0;
        spur      = 1'b0;
        exp_rd[0] = 16'hA200;
        exp_rd[1] = 16'hA300;
        exp_rd[2] = 16'hAC00;
        exp_rd[3] = 16'hAD00;

        vecs[0] = '{8'h34, 8'h12, 8'h78, 8'h56, 16'h1234, 16'h5678, 1'b0};
        vecs[1] = '{8'h00, 8'hF0, 8'h00, 8'h08, 16'hF000, 16'h0800, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 16'hFFFF, 16'h0001, 1'b0};

        // Reset values
        repeat (3) tick();
        check("rst_wrt", wrt, 1'b0);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_ptch", ptch_rt, 16'h0000);
        check("rst_az", AZ, 16'h0000);
        check("rst_vld", vld, 1'b0);

        // Init sequence with INT pulses during the wait and the config writes
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (k < 460) begin
            tick();
            k++;
            INT = ((cyc >= 100 && cyc < 110) || (cyc >= 300 && cyc < 320)) ? 1'b1 : 1'b0;
        end
        INT = 1'b0;
        check_init_seq("init");
        check("init_no_vld", vld_cnt, 0);

        // Spurious done while idle
        n = cmd_log.size();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        repeat (5) tick();
        check("spur_no_cmd", cmd_log.size(), n);
        check("spur_wrt", wrt, 1'b0);
        check("spur_no_vld", vld_cnt, 0);

        // Table-driven reads
        prev_vld_cyc = -1;
        for (int v = 0; v < 3; v++) begin
            resp_q.push_back(vecs[v].pl);
            resp_q.push_back(vecs[v].ph);
            resp_q.push_back(vecs[v].al);
            resp_q.push_back(vecs[v].ah);
            INT = 1'b1;
            k = 0;
            while (!(wrt && cmd == 16'hA200) && k < 50) begin
                tick();
                k++;
            end
            if (!(wrt && cmd == 16'hA200)) check($sformatf("v%0d_start_timeout", v), 0, 1);
            if (!vecs[v].hold) INT = 1'b0;
            k = 0;
            while (!vld && k < 300) begin
                tick();
                k++;
            end
            check($sformatf("v%0d_vld", v), vld, 1'b1);
            check($sformatf("v%0d_ptch", v), ptch_rt, vecs[v].exp_p);
            check($sformatf("v%0d_az", v), AZ, vecs[v].exp_a);
            n = cmd_log.size();
            for (int i = 0; i < 4; i++) begin
                if (n >= 4) check($sformatf("v%0d_rdcmd%0d", v, i), cmd_log[n-4+i], exp_rd[i]);
            end
            if (v > 0 && vecs[v-1].hold) check($sformatf("v%0d_b2b_gap", v), cyc - prev_vld_cyc, 130);
            prev_vld_cyc = cyc;
            tick();
            check($sformatf("v%0d_vld_once", v), vld, 1'b0);
            check($sformatf("v%0d_ptch_hold", v), ptch_rt, vecs[v].exp_p);
        end
        repeat (10) tick();
        check("vld_total", vld_cnt, 3);

        // Reset after the pitch-high read completes
        resp_q.push_back(8'h11);
        resp_q.push_back(8'h22);
        resp_q.push_back(8'h33);
        resp_q.push_back(8'h44);
        n = cmd_log.size();
        INT = 1'b1;
        wait_log(n + 3, 200, "mid_rd");
        INT = 1'b0;
        vld_before = vld_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ptch", ptch_rt, 16'h0000);
        check("mid_rst_az", AZ, 16'h0000);
        check("mid_rst_cmd", cmd, 16'h0000);
        check("mid_rst_wrt", wrt, 1'b0);
        repeat (3) tick();
        resp_q.delete();
        cmd_log.delete();
        first_wrt = -1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_log(4, 1000, "reinit");
        repeat (40) tick();
        check_init_seq("reinit");
        check("reinit_no_vld", vld_cnt, vld_before);
        check("reinit_ptch", ptch_rt, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
